// File: rtl/adc_capture_pkg.sv
// Shared types and sizing helpers for the ADC pre/post-trigger capture buffer.
package adc_capture_pkg;

  localparam int DEF_WIDTH = 12;
  localparam int DEF_DEPTH = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_POST,
    ST_DONE
  } state_t;

  // Pointer width for a buffer of 'value' entries; never less than one bit.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/adc_capture_buffer_ram.sv
// Simple dual-port sample store: one synchronous write port, one registered read port.
module capture_ram
  import adc_capture_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [clog2(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]          wdata,
  input  logic                      re,
  input  logic [clog2(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]          rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/adc_capture_buffer.sv
// Armed circular capture of ADC samples around a threshold crossing, frozen for
// oldest-first readout once the post-trigger window has been collected.
module adc_capture_buffer
  import adc_capture_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int POST  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sample,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] threshold,
  input  logic             arm,
  input  logic             rd_req,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             triggered,
  output logic             done
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] PRE_MIN   = CW'(DEPTH - POST);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_C    = CW'(DEPTH - 1);
  localparam logic [AW-1:0] POST_INIT = AW'(POST - 1);
  localparam logic [AW-1:0] POST_ONE  = AW'(1);

  state_t           state;
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [AW-1:0]    post_cnt;
  logic [CW-1:0]    count;
  logic [CW-1:0]    rd_cnt;
  logic             rd_pend;
  logic             rd_last;
  logic             wr_en;
  logic             rd_en;
  logic             trig_hit;
  logic [WIDTH-1:0] ram_rdata;

  // arm always wins: it drops a coincident sample and cancels a coincident read
  assign wr_en    = sample_valid && !arm && (state == ST_FILL || state == ST_POST);
  assign rd_en    = rd_req && !arm && (state == ST_DONE) && (rd_cnt != DEPTH_C);
  assign trig_hit = (state == ST_FILL) && sample_valid && !arm &&
                    (sample >= threshold) && (count >= PRE_MIN);

  capture_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wp),
    .wdata (sample),
    .re    (rd_en),
    .raddr (rp),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      wp        <= '0;
      rp        <= '0;
      post_cnt  <= '0;
      count     <= '0;
      rd_cnt    <= '0;
      rd_pend   <= 1'b0;
      rd_last   <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      busy      <= 1'b0;
      triggered <= 1'b0;
      done      <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      rd_pend  <= rd_en;
      rd_last  <= rd_en && (rd_cnt == LAST_C);
      if (arm) begin
        state     <= ST_FILL;
        wp        <= '0;
        rp        <= '0;
        post_cnt  <= '0;
        count     <= '0;
        rd_cnt    <= '0;
        busy      <= 1'b1;
        triggered <= 1'b0;
        done      <= 1'b0;
      end else begin
        if (wr_en) begin
          wp <= wp + 1'b1;
          if (count != DEPTH_C) count <= count + 1'b1;
        end
        case (state)
          ST_IDLE: ;
          ST_FILL: begin
            if (trig_hit) begin
              triggered <= 1'b1;
              post_cnt  <= POST_INIT;
              if (POST == 1) begin
                state  <= ST_DONE;
                busy   <= 1'b0;
                done   <= 1'b1;
                rp     <= wp + 1'b1;
                rd_cnt <= '0;
              end else begin
                state <= ST_POST;
              end
            end
          end
          ST_POST: begin
            if (sample_valid) begin
              post_cnt <= post_cnt - 1'b1;
              if (post_cnt == POST_ONE) begin
                // the entry after the final write is the oldest one
                state  <= ST_DONE;
                busy   <= 1'b0;
                done   <= 1'b1;
                rp     <= wp + 1'b1;
                rd_cnt <= '0;
              end
            end
          end
          ST_DONE: begin
            if (rd_en) begin
              rp     <= rp + 1'b1;
              rd_cnt <= rd_cnt + 1'b1;
            end
            if (rd_pend) begin
              rd_data  <= ram_rdata;
              rd_valid <= 1'b1;
              if (rd_last) begin
                state     <= ST_IDLE;
                done      <= 1'b0;
                triggered <= 1'b0;
                busy      <= 1'b0;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_buffer.sv
// Directed self-checking bench for adc_capture_buffer (DEPTH=64/POST=32 and DEPTH=8/POST=1).
module tb_adc_capture_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] sample = '0;
  logic [11:0] threshold = '0;
  logic        sample_valid = 1'b0, arm = 1'b0, rd_req = 1'b0;
  logic        sample_valid2 = 1'b0, arm2 = 1'b0, rd_req2 = 1'b0;
  logic [11:0] rd_data, rd_data2;
  logic        rd_valid, busy, triggered, done;
  logic        rd_valid2, busy2, triggered2, done2;

  int passed = 0;
  int total  = 0;

  logic        got_v    [0:79];
  logic [11:0] got_d    [0:79];
  logic        got_done [0:79];

  always #10 clk = ~clk;

  adc_capture_buffer #(.WIDTH(12), .DEPTH(64), .POST(32)) dut (
    .clk(clk), .rst(rst), .sample(sample), .sample_valid(sample_valid),
    .threshold(threshold), .arm(arm), .rd_req(rd_req), .rd_data(rd_data),
    .rd_valid(rd_valid), .busy(busy), .triggered(triggered), .done(done)
  );

  adc_capture_buffer #(.WIDTH(12), .DEPTH(8), .POST(1)) dut1 (
    .clk(clk), .rst(rst), .sample(sample), .sample_valid(sample_valid2),
    .threshold(threshold), .arm(arm2), .rd_req(rd_req2), .rd_data(rd_data2),
    .rd_valid(rd_valid2), .busy(busy2), .triggered(triggered2), .done(done2)
  );

  task automatic send(input int sel, input logic [11:0] v);
    @(negedge clk);
    sample = v;
    if (sel == 0) sample_valid = 1'b1; else sample_valid2 = 1'b1;
    @(negedge clk);
    sample_valid  = 1'b0;
    sample_valid2 = 1'b0;
  endtask

  task automatic pulse_arm(input int sel, input logic with_rd);
    @(negedge clk);
    if (sel == 0) begin arm = 1'b1; rd_req = with_rd; end
    else begin arm2 = 1'b1; rd_req2 = with_rd; end
    @(negedge clk);
    arm = 1'b0; arm2 = 1'b0; rd_req = 1'b0; rd_req2 = 1'b0;
  endtask

  // Slot i holds what was visible after the edge preceding negedge i; requests from slot i.
  task automatic do_reads(input int sel, input int nreq, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      got_v[i]    = (sel == 0) ? rd_valid : rd_valid2;
      got_d[i]    = (sel == 0) ? rd_data  : rd_data2;
      got_done[i] = (sel == 0) ? done     : done2;
      if (sel == 0) rd_req = (i < nreq); else rd_req2 = (i < nreq);
    end
    rd_req  = 1'b0;
    rd_req2 = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (rd_data !== 12'h000) $display("FAIL reset_rd_data: got %h expected 000", rd_data); else passed++;
    total++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    total++; if (triggered !== 1'b0) $display("FAIL reset_triggered: got %b expected 0", triggered); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passed++;
    total++; if (done2 !== 1'b0) $display("FAIL reset_done2: got %b expected 0", done2); else passed++;
    rst = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL post_reset_busy: got %b expected 0", busy); else passed++;
    $display("test_reset done");
  endtask

  task automatic test_rd_idle();
    do_reads(0, 2, 5);
    for (int i = 0; i < 5; i++) begin
      total++; if (got_v[i] !== 1'b0) $display("FAIL idle_rd_valid[%0d]: got %b expected 0", i, got_v[i]); else passed++;
    end
    $display("test_rd_idle done");
  endtask

  task automatic test_basic_capture();
    logic [11:0] e;
    threshold = 12'h800;
    pulse_arm(0, 1'b0);
    total++; if (busy !== 1'b1) $display("FAIL arm_busy: got %b expected 1", busy); else passed++;
    for (int i = 0; i < 40; i++) send(0, 12'(i));
    total++; if (triggered !== 1'b0) $display("FAIL basic_pre_trig: got %b expected 0", triggered); else passed++;
    send(0, 12'h900);
    total++; if (triggered !== 1'b1) $display("FAIL basic_trig: got %b expected 1", triggered); else passed++;
    total++; if (done !== 1'b0) $display("FAIL basic_trig_done: got %b expected 0", done); else passed++;
    for (int i = 1; i <= 30; i++) send(0, 12'h900 + 12'(i));
    total++; if (done !== 1'b0) $display("FAIL basic_done_early: got %b expected 0", done); else passed++;
    send(0, 12'h91F);
    total++; if (done !== 1'b1) $display("FAIL basic_done: got %b expected 1", done); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL basic_busy_done: got %b expected 0", busy); else passed++;
    total++; if (triggered !== 1'b1) $display("FAIL basic_trig_held: got %b expected 1", triggered); else passed++;
    // 65 back-to-back requests: 64 answered, the 65th lands in IDLE
    do_reads(0, 65, 68);
    for (int i = 0; i < 68; i++) begin
      total++;
      if (got_v[i] !== (i >= 2 && i <= 65)) $display("FAIL b2b_valid[%0d]: got %b expected %b", i, got_v[i], (i >= 2 && i <= 65));
      else passed++;
      if (i >= 2 && i <= 65) begin
        e = (i - 2 < 32) ? 12'h008 + 12'(i - 2) : 12'h900 + 12'(i - 34);
        total++; if (got_d[i] !== e) $display("FAIL b2b_data[%0d]: got %h expected %h", i - 2, got_d[i], e); else passed++;
      end
    end
    total++; if (got_done[64] !== 1'b1) $display("FAIL b2b_done_before_last: got %b expected 1", got_done[64]); else passed++;
    total++; if (got_done[65] !== 1'b0) $display("FAIL b2b_done_at_last: got %b expected 0", got_done[65]); else passed++;
    total++; if (triggered !== 1'b0) $display("FAIL b2b_trig_clear: got %b expected 0", triggered); else passed++;
    $display("test_basic_capture done");
  endtask

  task automatic test_early_crossing();
    threshold = 12'h800;
    pulse_arm(0, 1'b0);
    send(0, 12'hFFF);
    total++; if (triggered !== 1'b0) $display("FAIL early_first: got %b expected 0", triggered); else passed++;
    for (int i = 0; i < 30; i++) send(0, 12'h001);
    send(0, 12'hFFF);
    total++; if (triggered !== 1'b0) $display("FAIL early_count31: got %b expected 0", triggered); else passed++;
    send(0, 12'hFFF);
    total++; if (triggered !== 1'b1) $display("FAIL early_count32: got %b expected 1", triggered); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL early_post_busy: got %b expected 1", busy); else passed++;
    pulse_arm(0, 1'b0);
    total++; if (busy !== 1'b1) $display("FAIL rearm_post_busy: got %b expected 1", busy); else passed++;
    total++; if (triggered !== 1'b0) $display("FAIL rearm_post_trig: got %b expected 0", triggered); else passed++;
    total++; if (done !== 1'b0) $display("FAIL rearm_post_done: got %b expected 0", done); else passed++;
    $display("test_early_crossing done");
  endtask

  task automatic test_rearm_readout();
    // wp was 33 when re-armed above; a 64-sample capture must read back from 0x200
    threshold = 12'h000;
    for (int i = 0; i < 64; i++) send(0, 12'h200 + 12'(i));
    total++; if (done !== 1'b1) $display("FAIL rearm_cap_done: got %b expected 1", done); else passed++;
    do_reads(0, 3, 5);
    for (int i = 0; i < 5; i++) begin
      total++; if (got_v[i] !== (i >= 2)) $display("FAIL partial_valid[%0d]: got %b expected %b", i, got_v[i], (i >= 2)); else passed++;
      if (i >= 2) begin
        total++; if (got_d[i] !== 12'h200 + 12'(i - 2)) $display("FAIL partial_data[%0d]: got %h expected %h", i - 2, got_d[i], 12'h200 + 12'(i - 2)); else passed++;
      end
    end
    pulse_arm(0, 1'b1);
    total++; if (busy !== 1'b1) $display("FAIL rearm_rd_busy: got %b expected 1", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL rearm_rd_done: got %b expected 0", done); else passed++;
    total++; if (rd_valid !== 1'b0) $display("FAIL rearm_rd_valid0: got %b expected 0", rd_valid); else passed++;
    @(negedge clk);
    total++; if (rd_valid !== 1'b0) $display("FAIL rearm_rd_valid1: got %b expected 0", rd_valid); else passed++;
    for (int i = 0; i < 64; i++) send(0, 12'h300 + 12'(i));
    do_reads(0, 64, 67);
    for (int i = 2; i < 66; i++) begin
      total++; if (got_v[i] !== 1'b1 || got_d[i] !== 12'h300 + 12'(i - 2))
        $display("FAIL rearm_read[%0d]: got %b/%h expected 1/%h", i - 2, got_v[i], got_d[i], 12'h300 + 12'(i - 2));
      else passed++;
    end
    $display("test_rearm_readout done");
  endtask

  task automatic test_post1();
    logic [11:0] e;
    threshold = 12'h800;
    pulse_arm(1, 1'b0);
    for (int i = 0; i < 6; i++) send(1, 12'h010 + 12'(i));
    send(1, 12'hF00);
    total++; if (triggered2 !== 1'b0) $display("FAIL post1_early: got %b expected 0", triggered2); else passed++;
    send(1, 12'hABC);
    total++; if (done2 !== 1'b1) $display("FAIL post1_done: got %b expected 1", done2); else passed++;
    total++; if (triggered2 !== 1'b1) $display("FAIL post1_trig: got %b expected 1", triggered2); else passed++;
    total++; if (busy2 !== 1'b0) $display("FAIL post1_busy: got %b expected 0", busy2); else passed++;
    do_reads(1, 8, 11);
    for (int i = 2; i < 10; i++) begin
      e = (i - 2 < 6) ? 12'h010 + 12'(i - 2) : ((i == 8) ? 12'hF00 : 12'hABC);
      total++; if (got_v[i] !== 1'b1 || got_d[i] !== e)
        $display("FAIL post1_read[%0d]: got %b/%h expected 1/%h", i - 2, got_v[i], got_d[i], e);
      else passed++;
    end
    total++; if (got_done[9] !== 1'b0) $display("FAIL post1_idle: got %b expected 0", got_done[9]); else passed++;
    $display("test_post1 done");
  endtask

  task automatic test_async_reset();
    threshold = 12'h800;
    pulse_arm(0, 1'b0);
    for (int i = 0; i < 10; i++) send(0, 12'h050 + 12'(i));
    @(negedge clk);
    #3 rst = 1'b0;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL arst_busy: got %b expected 0", busy); else passed++;
    total++; if (rd_data !== 12'h000) $display("FAIL arst_rd_data: got %h expected 000", rd_data); else passed++;
    total++; if (triggered !== 1'b0 || done !== 1'b0 || rd_valid !== 1'b0)
      $display("FAIL arst_flags: got %b%b%b expected 000", triggered, done, rd_valid);
    else passed++;
    #2 rst = 1'b1;
    threshold = 12'h000;
    pulse_arm(0, 1'b0);
    for (int i = 0; i < 64; i++) send(0, 12'h400 + 12'(i));
    total++; if (done !== 1'b1) $display("FAIL arst_recap_done: got %b expected 1", done); else passed++;
    do_reads(0, 64, 67);
    for (int i = 2; i < 66; i++) begin
      total++; if (got_v[i] !== 1'b1 || got_d[i] !== 12'h400 + 12'(i - 2))
        $display("FAIL arst_read[%0d]: got %b/%h expected 1/%h", i - 2, got_v[i], got_d[i], 12'h400 + 12'(i - 2));
      else passed++;
    end
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_rd_idle();
    test_basic_capture();
    test_early_crossing();
    test_rearm_readout();
    test_post1();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
